// File: rtl/coproc_pkg.sv
// Shared opcodes, widths and FSM state encoding for the coprocessor execution controller.
package coproc_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ADRS_W  = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MEM_AW  = 6;
    localparam int unsigned MEM_DW  = 8;
    localparam int unsigned ALU_OPW = 3;

    localparam logic [OPC_W-1:0] OP_NOP      = 4'h0;
    localparam logic [OPC_W-1:0] OP_WR       = 4'h1;
    localparam logic [OPC_W-1:0] OP_RD       = 4'h2;
    localparam logic [OPC_W-1:0] OP_ALU_BASE = 4'h8;
    localparam logic [OPC_W-1:0] OP_ALU_LAST = 4'hE;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WR0    = 4'd1,
        S_WR1    = 4'd2,
        S_RD0    = 4'd3,
        S_RD1    = 4'd4,
        S_RD2    = 4'd5,
        S_ASTART = 4'd6,
        S_AWAIT  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
        return (op >= OP_ALU_BASE) && (op <= OP_ALU_LAST);
    endfunction

endpackage

// File: rtl/coproc_exec_ctrl_if.sv
// Instruction, element-memory, ALU and result signals between decoder side and controller.
interface coproc_exec_ctrl_if;
    import coproc_pkg::*;

    logic                 instr_valid;
    logic                 instr_ready;
    logic [OPC_W-1:0]     opcode;
    logic [ADRS_W-1:0]    adrs;
    logic [DATA_W-1:0]    data;
    logic [MEM_AW-1:0]    mem_addr;
    logic [MEM_DW-1:0]    mem_wdata;
    logic                 mem_we;
    logic [MEM_DW-1:0]    mem_rdata;
    logic                 alu_start;
    logic [ALU_OPW-1:0]   alu_op;
    logic                 alu_done;
    logic [DATA_W-1:0]    alu_result;
    logic [DATA_W-1:0]    result;
    logic                 done;
    logic                 error;

    modport master (
        output instr_valid, opcode, adrs, data, mem_rdata, alu_done, alu_result,
        input  instr_ready, mem_addr, mem_wdata, mem_we, alu_start, alu_op, result, done, error
    );

    modport slave (
        input  instr_valid, opcode, adrs, data, mem_rdata, alu_done, alu_result,
        output instr_ready, mem_addr, mem_wdata, mem_we, alu_start, alu_op, result, done, error
    );

endinterface

// File: rtl/coproc_exec_ctrl_alu_watchdog.sv
// Loadable down-counter; expired rises once TIMEOUT_CYCLES cycles have passed since start.
module alu_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    logic [TO_W-1:0] count;
    logic            active;

    // Loaded with TIMEOUT_CYCLES-1 so expired is high in the last allowed wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            active  <= 1'b0;
            expired <= 1'b0;
        end else if (start) begin
            count   <= TO_W'(TIMEOUT_CYCLES - 1);
            active  <= 1'b1;
            expired <= (TIMEOUT_CYCLES <= 1);
        end else if (clear) begin
            count   <= '0;
            active  <= 1'b0;
            expired <= 1'b0;
        end else if (active && (count != '0)) begin
            count   <= count - TO_W'(1);
            expired <= (count == TO_W'(1));
        end
    end

endmodule

// File: rtl/coproc_exec_ctrl.sv
// Sequences element-memory writes/reads or ALU dispatch for one decoded instruction at a time.
module coproc_exec_ctrl
    import coproc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    coproc_exec_ctrl_if.slave  bus
);

    state_t               state, state_n;
    logic [MEM_AW-1:0]    a_q;
    logic [MEM_DW-1:0]    lo_q;
    logic [MEM_DW-1:0]    hi_q;

    logic                 accept_c, addr_bad_c, fault_c;
    logic                 wd_start_c, wd_clear_c, wd_expired;
    logic [MEM_AW-1:0]    mem_addr_d;
    logic [MEM_DW-1:0]    mem_wdata_d;
    logic                 mem_we_d, alu_start_d;
    logic [ALU_OPW-1:0]   alu_op_d;
    logic [DATA_W-1:0]    result_d;

    assign accept_c   = bus.instr_valid && bus.instr_ready;
    assign addr_bad_c = |bus.adrs[ADRS_W-1:MEM_AW];
    assign wd_start_c = (state == S_ASTART);
    assign wd_clear_c = (state != S_AWAIT);

    alu_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (wd_start_c),
        .clear   (wd_clear_c),
        .expired (wd_expired)
    );

    // Next state, then the registered outputs for the state being entered.
    always_comb begin
        state_n     = state;
        fault_c     = 1'b0;
        result_d    = bus.result;
        alu_op_d    = bus.alu_op;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        alu_start_d = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if ((bus.opcode == OP_WR) && !addr_bad_c) begin
                        state_n = S_WR0;
                    end else if ((bus.opcode == OP_RD) && !addr_bad_c) begin
                        state_n = S_RD0;
                    end else if (is_alu_op(bus.opcode)) begin
                        state_n = S_ASTART;
                    end else begin
                        state_n = S_DONE;
                        fault_c = (bus.opcode != OP_NOP);
                    end
                end
            end
            S_WR0:    state_n = S_WR1;
            S_WR1:    state_n = S_DONE;
            S_RD0:    state_n = S_RD1;
            S_RD1:    state_n = S_RD2;
            S_RD2: begin
                state_n  = S_DONE;
                result_d = {hi_q, bus.mem_rdata};
            end
            S_ASTART: state_n = S_AWAIT;
            S_AWAIT: begin
                // A completion in the expiry cycle wins over the timeout.
                if (bus.alu_done) begin
                    state_n  = S_DONE;
                    result_d = bus.alu_result;
                end else if (wd_expired) begin
                    state_n = S_DONE;
                    fault_c = 1'b1;
                end
            end
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        unique case (state_n)
            S_WR0: begin
                mem_addr_d  = bus.adrs[MEM_AW-1:0];
                mem_wdata_d = bus.data[DATA_W-1:MEM_DW];
                mem_we_d    = 1'b1;
            end
            S_WR1: begin
                mem_addr_d  = a_q + MEM_AW'(1);
                mem_wdata_d = lo_q;
                mem_we_d    = 1'b1;
            end
            S_RD0:    mem_addr_d = bus.adrs[MEM_AW-1:0];
            S_RD1:    mem_addr_d = a_q + MEM_AW'(1);
            S_ASTART: begin
                alu_start_d = 1'b1;
                alu_op_d    = bus.opcode[ALU_OPW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            a_q             <= '0;
            lo_q            <= '0;
            hi_q            <= '0;
            bus.instr_ready <= 1'b1;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_we      <= 1'b0;
            bus.alu_start   <= 1'b0;
            bus.alu_op      <= '0;
            bus.result      <= '0;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
        end else begin
            state           <= state_n;
            bus.instr_ready <= (state_n == S_IDLE);
            bus.mem_addr    <= mem_addr_d;
            bus.mem_wdata   <= mem_wdata_d;
            bus.mem_we      <= mem_we_d;
            bus.alu_start   <= alu_start_d;
            bus.alu_op      <= alu_op_d;
            bus.result      <= result_d;
            bus.done        <= (state_n == S_DONE);
            bus.error       <= fault_c;
            if (state == S_RD1) begin
                hi_q <= bus.mem_rdata;
            end
            if (accept_c) begin
                a_q  <= bus.adrs[MEM_AW-1:0];
                lo_q <= bus.data[MEM_DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_coproc_exec_ctrl.sv
// Directed plus random instruction stream checked against a transaction-level reference model.
module tb_coproc_exec_ctrl;

    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coproc_exec_ctrl_if bus();

    coproc_exec_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  mem_arr [64];
    logic [7:0]  mem_ref [64];
    logic [15:0] res_ref;
    logic [7:0]  rd_pend;
    int          alu_delay, alu_due;
    logic [15:0] alu_res_drive;

    logic        s_ready, s_done, s_error, s_we, s_start;
    logic [5:0]  s_addr;
    logic [7:0]  s_wdata;
    logic [2:0]  s_op;
    logic [15:0] s_result;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the environment: sample outputs, then play memory and ALU.
    task automatic env_cycle(input int c, input bit gap);
        @(negedge clk);
        s_ready  = bus.instr_ready;
        s_done   = bus.done;
        s_error  = bus.error;
        s_we     = bus.mem_we;
        s_addr   = bus.mem_addr;
        s_wdata  = bus.mem_wdata;
        s_start  = bus.alu_start;
        s_op     = bus.alu_op;
        s_result = bus.result;
        if (s_we) mem_arr[s_addr] = s_wdata;
        bus.mem_rdata = rd_pend;
        rd_pend       = mem_arr[s_addr];
        if (s_start) alu_due = c + alu_delay;
        if (gap) begin
            bus.alu_done   = 1'($urandom_range(0, 1));
            bus.alu_result = 16'($urandom);
        end else if (c == alu_due) begin
            bus.alu_done   = 1'b1;
            bus.alu_result = alu_res_drive;
        end else begin
            bus.alu_done   = 1'b0;
            bus.alu_result = 16'($urandom);
        end
    endtask

    task automatic run_instr(input int idx, input logic [3:0] op, input logic [7:0] ad,
                             input logic [15:0] dt, input int d, input logic [15:0] ares);
        int exp_done, exp_starts, obs_done, starts, ready_bad, stray_err;
        logic exp_err, obs_err;
        logic [15:0] obs_res;
        logic [2:0] op_at_start;
        int exp_w[$];
        int obs_w[$];
        int a, a1;

        // Reference model: outcome of the whole instruction from the opcode rules.
        a = int'(ad) % 64;
        a1 = (a + 1) % 64;
        exp_err = 1'b0;
        exp_starts = 0;
        if ((op == 4'd1 || op == 4'd2) && ad >= 8'd64) begin
            exp_done = 1;
            exp_err  = 1'b1;
        end else if (op == 4'd1) begin
            exp_done = 3;
            exp_w.push_back(1 * 65536 + a * 256 + int'(dt) / 256);
            exp_w.push_back(2 * 65536 + a1 * 256 + int'(dt) % 256);
            mem_ref[a]  = 8'(int'(dt) / 256);
            mem_ref[a1] = 8'(int'(dt) % 256);
        end else if (op == 4'd2) begin
            exp_done = 4;
            res_ref  = 16'(int'(mem_ref[a]) * 256 + int'(mem_ref[a1]));
        end else if (op >= 4'd8 && op <= 4'd14) begin
            exp_starts = 1;
            if (d <= T) begin
                exp_done = d + 2;
                res_ref  = ares;
            end else begin
                exp_done = T + 2;
                exp_err  = 1'b1;
            end
        end else begin
            exp_done = 1;
            exp_err  = (op != 4'd0);
        end

        alu_delay     = d;
        alu_due       = -100;
        alu_res_drive = ares;
        check($sformatf("i%0d_ready_before", idx), 32'(s_ready), 32'd1);

        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.adrs        = ad;
        bus.data        = dt;
        @(posedge clk);
        #1;
        bus.opcode = 4'($urandom);
        bus.adrs   = 8'($urandom);
        bus.data   = 16'($urandom);

        obs_done = -1; obs_err = 1'b0; obs_res = '0;
        starts = 0; ready_bad = 0; stray_err = 0; op_at_start = '0;
        for (int c = 1; c <= 60; c++) begin
            env_cycle(c, 1'b0);
            if (s_we) obs_w.push_back(c * 65536 + int'(s_addr) * 256 + int'(s_wdata));
            if (s_start) begin
                starts++;
                op_at_start = s_op;
            end
            if (s_ready) ready_bad++;
            if (s_done) begin
                obs_done = c;
                obs_err  = s_error;
                obs_res  = s_result;
                break;
            end else if (s_error) begin
                stray_err++;
            end
        end
        bus.instr_valid = 1'b0;

        check($sformatf("i%0d_done_cycle", idx), 32'(obs_done), 32'(exp_done));
        check($sformatf("i%0d_error", idx), 32'(obs_err), 32'(exp_err));
        check($sformatf("i%0d_result", idx), 32'(obs_res), 32'(res_ref));
        check($sformatf("i%0d_alu_starts", idx), 32'(starts), 32'(exp_starts));
        if (exp_starts == 1) check($sformatf("i%0d_alu_op", idx), 32'(op_at_start), 32'(op[2:0]));
        check($sformatf("i%0d_write_count", idx), 32'(obs_w.size()), 32'(exp_w.size()));
        for (int k = 0; k < exp_w.size() && k < obs_w.size(); k++)
            check($sformatf("i%0d_write%0d", idx, k), 32'(obs_w[k]), 32'(exp_w[k]));
        check($sformatf("i%0d_ready_busy", idx), 32'(ready_bad), 32'd0);
        check($sformatf("i%0d_stray_error", idx), 32'(stray_err), 32'd0);

        env_cycle(obs_done + 1, 1'b1);
        check($sformatf("i%0d_ready_after", idx), 32'(s_ready), 32'd1);
        check($sformatf("i%0d_done_after", idx), 32'(s_done), 32'd0);
        check($sformatf("i%0d_result_hold", idx), 32'(s_result), 32'(res_ref));
    endtask

    initial begin
        int sel, d;
        logic [3:0] op;
        logic [7:0] ad;

        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.adrs        = '0;
        bus.data        = '0;
        bus.mem_rdata   = '0;
        bus.alu_done    = 1'b0;
        bus.alu_result  = '0;
        rd_pend = '0;
        res_ref = '0;
        alu_due = -100;
        alu_delay = 0;
        alu_res_drive = '0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 8'($urandom);
            mem_ref[i] = mem_arr[i];
        end

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_alu_start", 32'(bus.alu_start), 32'd0);
        check("rst_alu_op", 32'(bus.alu_op), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        env_cycle(0, 1'b1);

        run_instr(0, 4'h1, 8'h05, 16'hA55A, 0, 16'h0);
        run_instr(1, 4'h1, 8'h3F, 16'h1234, 0, 16'h0);
        run_instr(2, 4'h2, 8'h3F, 16'h0000, 0, 16'h0);
        run_instr(3, 4'h2, 8'h05, 16'h0000, 0, 16'h0);
        run_instr(4, 4'h9, 8'h00, 16'h0000, 7, 16'hBEEF);
        run_instr(5, 4'hC, 8'h00, 16'h0000, 1000, 16'h1111);
        run_instr(6, 4'h5, 8'h10, 16'hFFFF, 0, 16'h0);
        run_instr(7, 4'h2, 8'h45, 16'h0000, 0, 16'h0);
        run_instr(8, 4'h1, 8'hC1, 16'h7777, 0, 16'h0);
        run_instr(9, 4'h0, 8'h00, 16'h0000, 0, 16'h0);
        run_instr(10, 4'hA, 8'h00, 16'h0000, T, 16'h5A5A);
        run_instr(11, 4'hF, 8'h00, 16'h0000, 0, 16'h0);
        run_instr(12, 4'hE, 8'h00, 16'h0000, T + 1, 16'h2222);

        for (int i = 13; i < 53; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       op = 4'h1;
                1:       op = 4'h2;
                2:       op = 4'($urandom_range(8, 14));
                default: op = 4'($urandom_range(0, 15));
            endcase
            ad = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
            d  = $urandom_range(1, 20);
            run_instr(i, op, ad, 16'($urandom), d, 16'($urandom));
        end

        // Reset during the second write beat: first byte lands, second must not.
        check("rw_ready_before", 32'(s_ready), 32'd1);
        alu_due = -100;
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'h1;
        bus.adrs        = 8'h10;
        bus.data        = 16'hC3E1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        env_cycle(1, 1'b0);
        check("rw_wr0_we", 32'(s_we), 32'd1);
        check("rw_wr0_addr", 32'(s_addr), 32'h10);
        check("rw_wr0_data", 32'(s_wdata), 32'hC3);
        mem_ref[16] = 8'hC3;
        @(negedge clk);
        check("rw_wr1_we_before", 32'(bus.mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_we_async_drop", 32'(bus.mem_we), 32'd0);
        check("rw_ready_async", 32'(bus.instr_ready), 32'd1);
        check("rw_result_async", 32'(bus.result), 32'd0);
        res_ref = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            env_cycle(c, 1'b0);
            check($sformatf("rw_post_done%0d", c), 32'(s_done), 32'd0);
            check($sformatf("rw_post_ready%0d", c), 32'(s_ready), 32'd1);
            check($sformatf("rw_post_result%0d", c), 32'(s_result), 32'd0);
        end
        run_instr(60, 4'h2, 8'h10, 16'h0000, 0, 16'h0);
        run_instr(61, 4'h0, 8'h00, 16'h0000, 0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/coproc_exec_ctrl.md
# coproc_exec_ctrl

Execution controller that sits directly downstream of the instruction decoder in the matrix coprocessor. It accepts one decoded instruction per valid/ready handshake: opcode, 8-bit element address and 16-bit data. It sequences the element-memory writes and reads, or dispatches to the matrix ALU. It returns a 16-bit result with a done pulse, and flags illegal opcodes, illegal addresses and ALU timeouts.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: maximum wait in cycles for `alu_done` before an error is raised.
- `TO_W`, 10: counter width; must satisfy 2^TO_W >= TIMEOUT_CYCLES.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: decoded instruction present.
- `instr_ready` out 1: controller can accept.
- `opcode` in 4: decoded opcode.
- `adrs` in 8: decoded element address.
- `data` in 16: decoded immediate data.
- `mem_addr` out 6: element-memory address.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: write enable.
- `mem_rdata` in 8: read data, valid one cycle after `mem_addr`.
- `alu_start` out 1: one-cycle start pulse.
- `alu_op` out 3: ALU operation, equal to `opcode[2:0]`.
- `alu_done` in 1: ALU completion.
- `alu_result` in 16: ALU result, sampled when `alu_done` is high.
- `result` out 16: last RD or ALU result.
- `done` out 1: one-cycle pulse at the end of every accepted instruction.
- `error` out 1: one-cycle pulse coincident with `done` on a faulted instruction.

## Operation
Opcodes:
- 0: NOP.
- 1: WR.
- 2: RD.
- 8–14: ALU ops.
- 3–7 and 15: illegal.

Accept and latch:
- A transfer happens when `instr_valid && instr_ready`.
- `instr_ready` is 1 only in IDLE.
- Opcode, `adrs` and `data` are latched on accept. Input changes after accept are ignored.

Address rules:
- A = `adrs[5:0]`; A1 = (A+1) mod 64, computed 6-bit, so 63 wraps to 0.
- `adrs[7:6] != 0` on WR or RD is an illegal-address fault: no memory access, go straight to DONE with `error`.

Per-opcode sequence:
- WR: WR0 drives `mem_addr`=A, `mem_wdata`=`data[15:8]`, `mem_we`=1. WR1 drives A1, `data[7:0]`, `mem_we`=1. Then DONE. `result` is unchanged.
- RD: RD0 drives `mem_addr`=A. RD1 drives A1 and captures hi=`mem_rdata`. RD2 captures lo. In DONE, `result`={hi,lo}.
- ALU: ASTART pulses `alu_start` with `alu_op`. AWAIT waits for `alu_done`.
  - On `alu_done`: `result`=`alu_result`, go to DONE.
  - If `TIMEOUT_CYCLES` elapse in AWAIT: DONE with `error`; `result` is unchanged.
- NOP and illegal opcodes: DONE next cycle; illegal opcodes also pulse `error`.

State machine: IDLE → {WR0→WR1, RD0→RD1→RD2, ASTART→AWAIT, –} → DONE → IDLE.

Ignored events:
- `alu_done` outside AWAIT.
- `instr_valid` while not ready.

## Timing
- Accept edge = cycle 0. `done` is asserted in cycle:
  - NOP / illegal: 1.
  - WR: 3.
  - RD: 4.
  - ALU: `alu_done` cycle + 1.
- `instr_ready` is 0 from cycle 1 through the DONE cycle, and 1 in the cycle after DONE. Maximum throughput is one NOP every 2 cycles.
- `mem_we` is high in exactly 2 cycles per WR and never otherwise.
- `alu_start` is high in exactly 1 cycle per ALU op.
- `alu_done` in the same cycle as timeout expiry counts as success.
- Reset values: `instr_ready`=1 (IDLE) and all other outputs 0, including `result`=0.
- Reset asserted mid-operation aborts at once, returns to IDLE, and drops `mem_we` and `alu_start` asynchronously. No `done` pulse follows.

## Structure
- `coproc_pkg` holds:
  - opcode localparams `OP_NOP`, `OP_WR`, `OP_RD`, `OP_ALU_BASE`;
  - the state encoding;
  - the memory address width (6).
- Sub-module `alu_watchdog` provides a loadable down-counter with `start`, `clear` and `expired` signals, parameterised by `TIMEOUT_CYCLES`. The remaining logic is one FSM with registered outputs.

## Test plan
- **WR at A=0x05:** WR, `adrs`=0x05, `data`=0xA55A.
  - Required: `mem_we` on cycles 1–2 with (05,A5) then (06,5A); `done` on cycle 3; `error`=0.
- **RD wrap:** WR to `adrs`=0x3F with `data`=0x1234, then RD at 0x3F.
  - Required: second write at address 0x00; `result`=0x1234 with `done` on RD cycle 4.
- **ALU success:** opcode 0x9; ALU model asserts `alu_done` 7 cycles after `alu_start` with `alu_result`=0xBEEF.
  - Required: `alu_op`=1; `result`=0xBEEF; exactly one `alu_start`.
- **ALU timeout:** `TIMEOUT_CYCLES`=16, `alu_done` never asserted.
  - Required: `done` and `error` pulse together; `result` unchanged; `instr_ready` returns.
- **Illegal inputs:** opcode 0x5, then RD with `adrs`=0x45.
  - Required: each gives `done`+`error` with no `mem_we`.
- **Reset mid-WR:** `rst_n` low during WR1.
  - Required: `mem_we` drops immediately; after release `instr_ready`=1, `result`=0, no `done` pulse.
